hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Central pipeline hazard and stall controller for the five-stage RISC-V core. Every cycle it decides each stage's stall and flush, and it produces the 2-bit operand-source selects that steer the Execute-stage forwarding muxes. It also sequences the three multi-cycle events of the pipeline: multi-cycle ALU ops, outstanding data-bus accesses, and instruction fetches that are still in flight when a branch redirect occurs. It sits beside the pipeline registers in `pipeline/hazard/`.

## Interface
Parameters:
- none (widths come from `common::creg_addr_t`, `common::u1`).

Ports:
- `clk`  in  1  core clock
- `reset`  in  1  synchronous, active-high reset
- `rs1D`, `rs2D`  in  5  source registers of the instruction in Decode
- `rs1E`, `rs2E`  in  5  source registers of the instruction in Execute
- `writeregE`, `writeregM`, `writeregW`  in  5  destination register per stage
- `regwriteE`, `regwriteM`, `regwriteW`  in  1  destination write enable per stage
- `memreadE`  in  1  the instruction in Execute is a load
- `mc_startE`  in  1  a multi-cycle op issued in Execute (1-cycle pulse)
- `mc_done`  in  1  the multi-cycle unit's result is valid this cycle
- `dreq_validM`  in  1  Memory stage has a dbus request
- `ddata_ok`  in  1  dbus response this cycle
- `ireq_valid`  in  1  fetch request outstanding
- `idata_ok`  in  1  ibus response this cycle
- `redirectE`  in  1  branch or jump mispredict resolved in Execute
- `fwdA_E`, `fwdB_E`  out  2  operand select: 00 = register file (E), 01 = M result, 10 = W result
- `stallF`, `stallD`, `stallE`, `stallM`  out  1  hold the stage register
- `flushD`, `flushE`, `flushM`, `flushW`  out  1  insert a bubble into the stage register
- `ifetch_drop`  out  1  the current `idata_ok` response must be discarded

## Operation
- Forwarding (combinational), evaluated per operand. The register is `rs1E` for `fwdA_E` and `rs2E` for `fwdB_E`.
  - Select 01 when the register is nonzero, equals `writeregM`, and `regwriteM` is set.
  - Otherwise select 10 when it is nonzero, equals `writeregW`, and `regwriteW` is set.
  - Otherwise select 00. When M and W both match, M wins.
- Registered state:
  - FSM `mc_state` ∈ {RUN, MC_BUSY}.
  - Flag `drop_pend`.
- FSM transitions:
  - RUN→MC_BUSY when `mc_startE` is set, no dbus stall is active, and `mc_done` is 0.
  - MC_BUSY→RUN in the cycle `mc_done` is set.
  - A `mc_startE` that arrives with `mc_done` already set completes in that same cycle and the FSM stays in RUN.
- Stall causes, in priority order (a higher cause masks all lower ones):
  1. dstall = `dreq_validM` & !`ddata_ok` → `stallF`/`stallD`/`stallE`/`stallM`=1, `flushW`=1.
  2. mcstall = (MC_BUSY or `mc_startE`) & !`mc_done` → `stallF`/`stallD`/`stallE`=1, `flushM`=1.
  3. luse = `memreadE` & `regwriteE` & `writeregE`≠0 & (`writeregE`==`rs1D` | `writeregE`==`rs2D`) → `stallF`/`stallD`=1, `flushE`=1.
  4. redirect = `redirectE` → `flushD`=1 and `flushE`=1. The redirect is acted on only when neither dstall nor mcstall is active; Execute holds the branch, so `redirectE` is re-presented. Redirect overrides luse, because the Decode instruction is squashed anyway.
  5. istall = `ireq_valid` & !`idata_ok` & !redirect → `stallF`=1, `flushD`=1 (only if Decode is not stalled).
- Fetch drop:
  - `drop_pend` is set when a redirect is acted on while `ireq_valid` & !`idata_ok`.
  - `ifetch_drop` = `drop_pend` & `idata_ok`. `drop_pend` clears in that same cycle.
  - While `drop_pend` is set, Fetch is stalled and Decode is flushed.
- Any output not driven by an active cause is 0.

## Timing
- Forward selects and stall/flush outputs are combinational from the inputs and the registered state; they take effect at the next `clk` edge.
- On `reset`: `mc_state`=RUN, `drop_pend`=0, perf counters=0. With idle inputs, every output is 0.
- Reset mid-operation abandons MC_BUSY and any pending drop on the same edge.
- Load-use costs exactly 1 bubble. The dependent instruction reaches Execute one cycle later with `fwdX_E`=01 from the load in M.
- A multi-cycle op with latency N (N−1 cycles without `mc_done`) stalls F/D/E for N−1 cycles.
- A dbus wait of k cycles holds M for k cycles and injects k W bubbles.

## Configuration
- `HAZARD_PERF_EN` defined: adds outputs `perf_stall_cyc` (32-bit) and `perf_luse_cnt` (32-bit).
  - `perf_stall_cyc` increments every cycle `stallF` is 1.
  - `perf_luse_cnt` increments once per load-use bubble.
  - Both wrap at 2³²−1→0 and clear on `reset`.
- Undefined: these ports and counters are absent; all other behaviour is identical.

## Test plan
- `rs1E`=5, `writeregM`=5, `regwriteM`=1, `writeregW`=5, `regwriteW`=1 → `fwdA_E`=01. Same with `rs1E`=0 → 00.
- Load to x7 in E (`memreadE`=1), `rs2D`=7 → one cycle with `stallF`=`stallD`=`flushE`=1. Next cycle, with `rs2E`=7 and `writeregM`=7 → `fwdB_E`=01, no stall.
- `mc_startE` pulse, `mc_done` after 3 cycles → `stallE`=1 and `flushM`=1 for exactly 3 cycles, FSM back to RUN.
- `dreq_validM`=1, `ddata_ok`=0 for 4 cycles while luse is also true → only the dstall pattern appears for 4 cycles (`flushE`=0); luse is applied afterwards.
- `redirectE` while `ireq_valid`=1 and `idata_ok`=0 → `flushD`=`flushE`=1; the next `idata_ok` gives `ifetch_drop`=1 for exactly one cycle.
- `reset` asserted while in MC_BUSY with `drop_pend`=1 → next cycle all outputs 0; with `HAZARD_PERF_EN`, both counters read 0.

Source files
------------

// File: rtl/hazard_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : hazard_ctrl                                                |
// | Description : Pipeline hazard/stall controller for the five-stage core.  |
// |               Generates Execute forwarding selects, per-stage stall and  |
// |               flush, and sequences multi-cycle ALU ops, dbus waits and   |
// |               discarding of in-flight fetches after a redirect.          |
// |               Optional perf counters: define HAZARD_PERF_EN.             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module hazard_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] rs1D,
  input  logic [4:0] rs2D,
  input  logic [4:0] rs1E,
  input  logic [4:0] rs2E,
  input  logic [4:0] writeregE,
  input  logic [4:0] writeregM,
  input  logic [4:0] writeregW,
  input  logic       regwriteE,
  input  logic       regwriteM,
  input  logic       regwriteW,
  input  logic       memreadE,
  input  logic       mc_startE,
  input  logic       mc_done,
  input  logic       dreq_validM,
  input  logic       ddata_ok,
  input  logic       ireq_valid,
  input  logic       idata_ok,
  input  logic       redirectE,
  output logic [1:0] fwdA_E,
  output logic [1:0] fwdB_E,
  output logic       stallF,
  output logic       stallD,
  output logic       stallE,
  output logic       stallM,
  output logic       flushD,
  output logic       flushE,
  output logic       flushM,
  output logic       flushW,
  output logic       ifetch_drop
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] perf_stall_cyc,
  output logic [31:0] perf_luse_cnt
`endif
);

  localparam logic [1:0] c_FWD_RF = 2'b00;
  localparam logic [1:0] c_FWD_M  = 2'b01;
  localparam logic [1:0] c_FWD_W  = 2'b10;

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    MC_BUSY = 1'b1
  } mc_state_t;

  mc_state_t mc_state_q, mc_state_d;
  logic      drop_pend_q, drop_pend_d;

  logic w_dstall;
  logic w_mcstall;
  logic w_luse;
  logic w_redirect_act;
  logic w_luse_act;
  logic w_istall;

  // Newest producer wins: M result shadows W result; x0 is never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic [4:0] wm, input logic rwm,
                                         input logic [4:0] ww, input logic rww);
    logic [1:0] sel;
    sel = c_FWD_RF;
    if (rs != 5'd0 && rs == wm && rwm)      sel = c_FWD_M;
    else if (rs != 5'd0 && rs == ww && rww) sel = c_FWD_W;
    return sel;
  endfunction

  assign fwdA_E = fwd_sel(rs1E, writeregM, regwriteM, writeregW, regwriteW);
  assign fwdB_E = fwd_sel(rs2E, writeregM, regwriteM, writeregW, regwriteW);

  // Raw hazard causes; priority is resolved below.
  assign w_dstall  = dreq_validM & ~ddata_ok;
  assign w_mcstall = ((mc_state_q == MC_BUSY) | mc_startE) & ~mc_done;
  assign w_luse    = memreadE & regwriteE & (writeregE != 5'd0) &
                     ((writeregE == rs1D) | (writeregE == rs2D));
  assign w_istall  = ireq_valid & ~idata_ok & ~redirectE;

  // A redirect only takes effect once Execute is free to move; until then the
  // branch stays in Execute and presents redirectE again.
  assign w_redirect_act = redirectE & ~w_dstall & ~w_mcstall;
  assign w_luse_act     = w_luse & ~w_dstall & ~w_mcstall & ~redirectE;

  assign ifetch_drop = drop_pend_q & idata_ok;

  // Priority-ordered stall/flush decode; a higher cause masks all lower ones.
  always_comb begin
    stallF = 1'b0;
    stallD = 1'b0;
    stallE = 1'b0;
    stallM = 1'b0;
    flushD = 1'b0;
    flushE = 1'b0;
    flushM = 1'b0;
    flushW = 1'b0;
    if (w_dstall) begin
      stallF = 1'b1;
      stallD = 1'b1;
      stallE = 1'b1;
      stallM = 1'b1;
      flushW = 1'b1;
    end else if (w_mcstall) begin
      stallF = 1'b1;
      stallD = 1'b1;
      stallE = 1'b1;
      flushM = 1'b1;
    end else if (redirectE) begin
      // Decode is squashed anyway, so a pending load-use is irrelevant.
      stallF = drop_pend_q;
      flushD = 1'b1;
      flushE = 1'b1;
    end else if (w_luse) begin
      stallF = 1'b1;
      stallD = 1'b1;
      flushE = 1'b1;
    end else if (w_istall | drop_pend_q) begin
      // Decode is free here, so it can take a bubble while Fetch waits.
      stallF = 1'b1;
      flushD = 1'b1;
    end
  end

  // Next-state for the multi-cycle FSM and the stale-fetch drop flag.
  always_comb begin
    mc_state_d  = mc_state_q;
    drop_pend_d = drop_pend_q;
    case (mc_state_q)
      RUN:     if (mc_startE & ~w_dstall & ~mc_done) mc_state_d = MC_BUSY;
      MC_BUSY: if (mc_done)                          mc_state_d = RUN;
      default:                                       mc_state_d = RUN;
    endcase
    if (drop_pend_q & idata_ok)
      drop_pend_d = 1'b0;
    else if (w_redirect_act & ireq_valid & ~idata_ok)
      drop_pend_d = 1'b1;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      mc_state_q  <= RUN;
      drop_pend_q <= 1'b0;
    end else begin
      mc_state_q  <= mc_state_d;
      drop_pend_q <= drop_pend_d;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_cyc_q;
  logic [31:0] perf_luse_cnt_q;

  // Free-running, wrapping event counters for stall cycles and load-use bubbles.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall_cyc_q <= 32'd0;
      perf_luse_cnt_q  <= 32'd0;
    end else begin
      if (stallF)     perf_stall_cyc_q <= perf_stall_cyc_q + 32'd1;
      if (w_luse_act) perf_luse_cnt_q  <= perf_luse_cnt_q + 32'd1;
    end
  end

  assign perf_stall_cyc = perf_stall_cyc_q;
  assign perf_luse_cnt  = perf_luse_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_hazard_ctrl                                             |
// | Description : Self-checking bench for hazard_ctrl. Each cycle's expected |
// |               output vector is queued when stimulus is driven and popped |
// |               when the outputs are sampled mid-cycle.                    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rs1D, rs2D, rs1E, rs2E, writeregE, writeregM, writeregW;
  logic       regwriteE, regwriteM, regwriteW, memreadE, mc_startE, mc_done;
  logic       dreq_validM, ddata_ok, ireq_valid, idata_ok, redirectE;
  logic [1:0] fwdA_E, fwdB_E;
  logic       stallF, stallD, stallE, stallM;
  logic       flushD, flushE, flushM, flushW, ifetch_drop;
`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_cyc, perf_luse_cnt;
`endif

  int errors = 0;
  int checks = 0;

  logic [12:0] exp_q[$];
  string       tag_q[$];

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk(clk), .reset(reset),
    .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E),
    .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
    .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
    .memreadE(memreadE), .mc_startE(mc_startE), .mc_done(mc_done),
    .dreq_validM(dreq_validM), .ddata_ok(ddata_ok),
    .ireq_valid(ireq_valid), .idata_ok(idata_ok), .redirectE(redirectE),
    .fwdA_E(fwdA_E), .fwdB_E(fwdB_E),
    .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
    .flushD(flushD), .flushE(flushE), .flushM(flushM), .flushW(flushW),
    .ifetch_drop(ifetch_drop)
`ifdef HAZARD_PERF_EN
    ,
    .perf_stall_cyc(perf_stall_cyc), .perf_luse_cnt(perf_luse_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Expected vector layout: {fwdA, fwdB, stall F/D/E/M, flush D/E/M/W, drop}
  function automatic logic [12:0] ev(input logic [1:0] fa, input logic [1:0] fb,
                                     input logic [3:0] st, input logic [3:0] fl,
                                     input logic dr);
    return {fa, fb, st, fl, dr};
  endfunction

  // Queue the expectation for the inputs just driven, sample mid-cycle, advance.
  task automatic cyc(input string tag, input logic [12:0] exp);
    logic [12:0] e;
    string       t;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    @(negedge clk);
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    check(t, {19'd0, fwdA_E, fwdB_E, stallF, stallD, stallE, stallM,
              flushD, flushE, flushM, flushW, ifetch_drop}, {19'd0, e});
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rs1D = 0; rs2D = 0; rs1E = 0; rs2E = 0;
    writeregE = 0; writeregM = 0; writeregW = 0;
    regwriteE = 0; regwriteM = 0; regwriteW = 0; memreadE = 0;
    mc_startE = 0; mc_done = 0; dreq_validM = 0; ddata_ok = 0;
    ireq_valid = 0; idata_ok = 0; redirectE = 0;
  endtask

  task automatic set_luse();
    memreadE = 1; regwriteE = 1; writeregE = 5'd7; rs2D = 5'd7;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    reset = 1;
    @(posedge clk); @(posedge clk); #1;
    cyc("reset_idle", ev(2'b00, 2'b00, 4'b0000, 4'b0000, 1'b0));
`ifdef HAZARD_PERF_EN
    check("perf_stall_rst", perf_stall_cyc, 32'd0);
    check("perf_luse_rst", perf_luse_cnt, 32'd0);
`endif
    reset = 0;

    // Forwarding
    rs1E = 5; writeregM = 5; regwriteM = 1; writeregW = 5; regwriteW = 1;
    cyc("fwd_m_wins", ev(2'b01, 2'b00, 4'b0000, 4'b0000, 1'b0));
    rs1E = 0;
    cyc("fwd_x0", ev(2'b00, 2'b00, 4'b0000, 4'b0000, 1'b0));
    rs2E = 9; writeregW = 9; regwriteM = 0;
    cyc("fwd_w", ev(2'b00, 2'b10, 4'b0000, 4'b0000, 1'b0));
    regwriteW = 0;
    cyc("fwd_w_nowe", ev(2'b00, 2'b00, 4'b0000, 4'b0000, 1'b0));
    idle();

    // Load-use: one bubble, then forward from M
    set_luse();
    cyc("luse_bubble", ev(2'b00, 2'b00, 4'b1100, 4'b0100, 1'b0));
    idle(); rs2E = 7; writeregM = 7; regwriteM = 1;
    cyc("luse_fwd", ev(2'b00, 2'b01, 4'b0000, 4'b0000, 1'b0));
    idle();

    // Multi-cycle op, mc_done three cycles after start
    mc_startE = 1;
    cyc("mc_start", ev(2'b00, 2'b00, 4'b1110, 4'b0010, 1'b0));
    mc_startE = 0;
    cyc("mc_busy1", ev(2'b00, 2'b00, 4'b1110, 4'b0010, 1'b0));
    cyc("mc_busy2", ev(2'b00, 2'b00, 4'b1110, 4'b0010, 1'b0));
    mc_done = 1;
    cyc("mc_done", ev(2'b00, 2'b00, 4'b0000, 4'b0000, 1'b0));
    mc_done = 0;
    cyc("mc_run", ev(2'b00, 2'b00, 4'b0000, 4'b0000, 1'b0));
    mc_startE = 1; mc_done = 1;
    cyc("mc_same_cyc", ev(2'b00, 2'b00, 4'b0000, 4'b0000, 1'b0));
    idle();
    cyc("mc_same_run", ev(2'b00, 2'b00, 4'b0000, 4'b0000, 1'b0));

    // dbus wait of 4 cycles masks load-use, which follows afterwards
    set_luse(); dreq_validM = 1;
    for (int i = 0; i < 4; i++)
      cyc($sformatf("dstall_%0d", i), ev(2'b00, 2'b00, 4'b1111, 4'b0001, 1'b0));
    dreq_validM = 0;
    cyc("luse_after_d", ev(2'b00, 2'b00, 4'b1100, 4'b0100, 1'b0));
    idle();

    // mc_startE under dstall must not enter MC_BUSY
    mc_startE = 1; dreq_validM = 1;
    cyc("mc_in_dstall", ev(2'b00, 2'b00, 4'b1111, 4'b0001, 1'b0));
    idle();
    cyc("mc_not_busy", ev(2'b00, 2'b00, 4'b0000, 4'b0000, 1'b0));

    // Redirect with outstanding fetch; drop exactly one response
    redirectE = 1; ireq_valid = 1;
    cyc("redir", ev(2'b00, 2'b00, 4'b0000, 4'b1100, 1'b0));
    redirectE = 0;
    cyc("drop_wait", ev(2'b00, 2'b00, 4'b1000, 4'b1000, 1'b0));
    idata_ok = 1;
    cyc("drop_hit", ev(2'b00, 2'b00, 4'b1000, 4'b1000, 1'b1));
    cyc("drop_once", ev(2'b00, 2'b00, 4'b0000, 4'b0000, 1'b0));
    idle();

    // Redirect overrides load-use; istall masked by load-use; plain istall
    set_luse(); redirectE = 1;
    cyc("redir_over_luse", ev(2'b00, 2'b00, 4'b0000, 4'b1100, 1'b0));
    idle(); set_luse(); ireq_valid = 1; idata_ok = 1;
    cyc("luse_no_drop", ev(2'b00, 2'b00, 4'b1100, 4'b0100, 1'b0));
    idata_ok = 0;
    cyc("luse_over_istall", ev(2'b00, 2'b00, 4'b1100, 4'b0100, 1'b0));
    idle(); ireq_valid = 1;
    cyc("istall", ev(2'b00, 2'b00, 4'b1000, 4'b1000, 1'b0));
    idle();

    // Redirect during mcstall is not acted on and arms no drop
    mc_startE = 1; redirectE = 1; ireq_valid = 1;
    cyc("redir_in_mc", ev(2'b00, 2'b00, 4'b1110, 4'b0010, 1'b0));
    mc_startE = 0; redirectE = 0; ireq_valid = 1; idata_ok = 1; mc_done = 1;
    cyc("redir_no_drop", ev(2'b00, 2'b00, 4'b0000, 4'b0000, 1'b0));
    idle();

    // Reset while MC_BUSY with drop pending
    redirectE = 1; ireq_valid = 1;
    cyc("pre_rst_redir", ev(2'b00, 2'b00, 4'b0000, 4'b1100, 1'b0));
    redirectE = 0; mc_startE = 1;
    cyc("pre_rst_mc", ev(2'b00, 2'b00, 4'b1110, 4'b0010, 1'b0));
    idle();
    cyc("pre_rst_busy", ev(2'b00, 2'b00, 4'b1110, 4'b0010, 1'b0));
    reset = 1;
    cyc("rst_edge", ev(2'b00, 2'b00, 4'b1110, 4'b0010, 1'b0));
    reset = 0;
    cyc("post_rst_idle", ev(2'b00, 2'b00, 4'b0000, 4'b0000, 1'b0));
`ifdef HAZARD_PERF_EN
    check("perf_stall_clr", perf_stall_cyc, 32'd0);
    check("perf_luse_clr", perf_luse_cnt, 32'd0);
`endif
    idata_ok = 1;
    cyc("post_rst_nodrop", ev(2'b00, 2'b00, 4'b0000, 4'b0000, 1'b0));
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
